// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine. It runs one layer pass when start is seen,
// streams one weight row per chunk from the shared ROM, and feeds operand
// pairs to the shared combinational multiply-adder. It accumulates the partial
// sums, then shifts, saturates and optionally applies ReLU. The N_OUT results
// are held on data_to_ram for the next layer.
module fc_layer_engine #(
  parameter int BIT       = 8,
  parameter int LANES     = 128,
  parameter int CHUNKS    = 8,
  parameter int N_OUT     = 10,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0,
  parameter int ACC_W     = 24,
  parameter int SHIFT     = 0,
  parameter int RELU      = 1
) (
  input  logic                           clk,
  input  logic                           iRst,
  input  logic                           ena,
  input  logic                           start,
  input  logic [CHUNKS*LANES*BIT-1:0]    data_from_ram,
  input  logic [LANES*BIT-1:0]           data_from_rom,
  input  logic [2*BIT-1:0]               data_from_MultAdder,
  output logic [ADDR_W-1:0]              addr_to_rom,
  output logic [LANES*BIT-1:0]           opr1_to_MultAdder,
  output logic [LANES*BIT-1:0]           opr2_to_MultAdder,
  output logic [N_OUT*BIT-1:0]           data_to_ram,
  output logic                           busy,
  output logic                           done
);

  localparam int ROW_W = LANES * BIT;
  localparam int N_W   = (N_OUT  > 1) ? $clog2(N_OUT)  : 1;
  localparam int C_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [N_W-1:0]          N_LAST = N_W'(N_OUT - 1);
  localparam logic [C_W-1:0]          C_LAST = C_W'(CHUNKS - 1);
  localparam logic signed [ACC_W-1:0] MAX_V  = ACC_W'((1 << (BIT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V  = -MAX_V - ACC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                      state;
  logic [CHUNKS*LANES*BIT-1:0] vec;
  logic signed [ACC_W-1:0]     acc;
  logic [N_W-1:0]              n_idx;
  logic [C_W-1:0]              c_idx;

  logic signed [ACC_W-1:0]     mac_ext;
  logic signed [ACC_W-1:0]     shifted;
  logic [BIT-1:0]              res;

  // Sign-extend the multiply-adder result into the accumulator width.
  assign mac_ext = {{(ACC_W - 2*BIT){data_from_MultAdder[2*BIT-1]}}, data_from_MultAdder};
  assign shifted = acc >>> SHIFT;

  // Operands are non-zero only in MAC, so the shared operand mux sees clean values.
  assign opr1_to_MultAdder = (state == ST_MAC) ? data_from_rom : '0;
  assign opr2_to_MultAdder = (state == ST_MAC) ? vec[c_idx*ROW_W +: ROW_W] : '0;

  // Post-processing of the accumulator: saturate to BIT bits, then ReLU.
  always_comb begin
    // NOTE: res gets a default on every path first, so no latch is inferred.
    res = shifted[BIT-1:0];
    if (shifted > MAX_V) begin
      res = MAX_V[BIT-1:0];
    end else if (shifted < MIN_V) begin
      res = MIN_V[BIT-1:0];
    end
    if ((RELU != 0) && (shifted < 0)) begin
      res = '0;
    end
  end

  // Layer sequencer: start acceptance, row fetch, accumulate, write-back.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples pre-edge values.
    if (iRst) begin
      state       <= ST_IDLE;
      addr_to_rom <= '0;
      data_to_ram <= '0;
      acc         <= '0;
      n_idx       <= '0;
      c_idx       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      // NOTE: vec is left out of reset on purpose. It is always loaded at
      // start before anything reads it.
    end else if (ena) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec         <= data_from_ram;
            addr_to_rom <= ADDR_W'(BASE_ADDR);
            n_idx       <= '0;
            c_idx       <= '0;
            acc         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          state <= ST_MAC;
        end

        ST_MAC: begin
          acc <= acc + mac_ext;
          if (c_idx != C_LAST) begin
            c_idx       <= c_idx + C_W'(1);
            addr_to_rom <= addr_to_rom + ADDR_W'(1);
            state       <= ST_FETCH;
          end else begin
            state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          data_to_ram[n_idx*BIT +: BIT] <= res;
          acc   <= '0;
          c_idx <= '0;
          if (n_idx != N_LAST) begin
            n_idx       <= n_idx + N_W'(1);
            addr_to_rom <= addr_to_rom + ADDR_W'(1);
            state       <= ST_FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine in a small configuration with two
// lanes, two chunks, two neurons and base address 100. It uses a behavioural
// synchronous ROM and a dot-product multiply-adder. Two instances run in
// lock-step, one with ReLU and one without. Expected results go onto a
// scoreboard at start and are popped when done rises.
module tb_fc_layer_engine;

  localparam int BIT       = 8;
  localparam int LANES     = 2;
  localparam int CHUNKS    = 2;
  localparam int N_OUT     = 2;
  localparam int ADDR_W    = 11;
  localparam int BASE_ADDR = 100;
  localparam int ACC_W     = 24;
  localparam int ROW_W     = LANES * BIT;
  localparam int VEC_W     = CHUNKS * LANES * BIT;
  localparam int RES_W     = N_OUT * BIT;

  logic clk = 1'b0;
  logic iRst, ena, start;
  logic [VEC_W-1:0] data_from_ram;

  logic [ROW_W-1:0]  rom_q, rom_q_nr;
  logic [2*BIT-1:0]  mult, mult_nr;
  logic [ADDR_W-1:0] addr, addr_nr;
  logic [ROW_W-1:0]  opr1, opr2, opr1_nr, opr2_nr;
  logic [RES_W-1:0]  results, results_nr;
  logic              busy, done, busy_nr, done_nr;

  logic [ROW_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

  typedef struct {
    logic [RES_W-1:0] res;
    logic [RES_W-1:0] res_nr;
    int               done_edge;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fc_layer_engine #(
    .BIT(BIT), .LANES(LANES), .CHUNKS(CHUNKS), .N_OUT(N_OUT), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR), .ACC_W(ACC_W), .SHIFT(0), .RELU(1)
  ) u_dut (
    .clk(clk), .iRst(iRst), .ena(ena), .start(start),
    .data_from_ram(data_from_ram), .data_from_rom(rom_q),
    .data_from_MultAdder(mult), .addr_to_rom(addr),
    .opr1_to_MultAdder(opr1), .opr2_to_MultAdder(opr2),
    .data_to_ram(results), .busy(busy), .done(done)
  );

  fc_layer_engine #(
    .BIT(BIT), .LANES(LANES), .CHUNKS(CHUNKS), .N_OUT(N_OUT), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR), .ACC_W(ACC_W), .SHIFT(0), .RELU(0)
  ) u_dut_nr (
    .clk(clk), .iRst(iRst), .ena(ena), .start(start),
    .data_from_ram(data_from_ram), .data_from_rom(rom_q_nr),
    .data_from_MultAdder(mult_nr), .addr_to_rom(addr_nr),
    .opr1_to_MultAdder(opr1_nr), .opr2_to_MultAdder(opr2_nr),
    .data_to_ram(results_nr), .busy(busy_nr), .done(done_nr)
  );

  // Synchronous ROM: a row is valid one cycle after its address.
  always @(posedge clk) begin
    rom_q    <= rom_mem[addr];
    rom_q_nr <= rom_mem[addr_nr];
  end

  function automatic logic [2*BIT-1:0] dot(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    int s;
    s = 0;
    for (int l = 0; l < LANES; l++) begin
      s += int'($signed(a[l*BIT +: BIT])) * int'($signed(b[l*BIT +: BIT]));
    end
    return s[2*BIT-1:0];
  endfunction

  // Behavioural combinational multiply-adder.
  always_comb begin
    mult    = dot(opr1, opr2);
    mult_nr = dot(opr1_nr, opr2_nr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference neuron: every weight is w and every activation is x.
  function automatic logic [BIT-1:0] model(input int w, input int x, input bit relu);
    int s;
    s = 0;
    for (int i = 0; i < CHUNKS*LANES; i++) s += w * x;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return s[BIT-1:0];
  endfunction

  task automatic load(input int w0, input int w1, input int x);
    logic [BIT-1:0] b0, b1, bx;
    b0 = w0[BIT-1:0];
    b1 = w1[BIT-1:0];
    bx = x[BIT-1:0];
    for (int c = 0; c < CHUNKS; c++) begin
      rom_mem[BASE_ADDR + c]          = {LANES{b0}};
      rom_mem[BASE_ADDR + CHUNKS + c] = {LANES{b1}};
    end
    data_from_ram = {(CHUNKS*LANES){bx}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete pass. The accept edge is edge 1. ena_gap disables the three
  // edges after edge ena_gap. repulse re-asserts start at that edge, with
  // changed activations.
  task automatic run_pass(input string name, input int w0, input int w1, input int x,
                          input int ena_gap, input int repulse, input int exp_edge);
    exp_t e;
    exp_t got_e;
    int   ecnt;
    int   addr_seen[$];
    load(w0, w1, x);
    e.res       = {model(w1, x, 1'b1), model(w0, x, 1'b1)};
    e.res_nr    = {model(w1, x, 1'b0), model(w0, x, 1'b0)};
    e.done_edge = exp_edge;
    sb.push_back(e);

    start = 1'b1;
    tick();
    start = 1'b0;
    ecnt  = 1;
    check({name, "_busy_accept"}, 32'(busy), 32'd1);
    check({name, "_done_accept"}, 32'(done), 32'd0);
    addr_seen.push_back(int'(addr));

    while (!done && ecnt < 200) begin
      if (ena_gap != 0 && ecnt == ena_gap)     ena = 1'b0;
      if (ena_gap != 0 && ecnt == ena_gap + 3) ena = 1'b1;
      if (repulse != 0 && ecnt == repulse - 1) begin
        start         = 1'b1;
        data_from_ram = {(CHUNKS*LANES){8'h02}};
      end
      if (repulse != 0 && ecnt == repulse) start = 1'b0;
      tick();
      ecnt++;
      if (int'(addr) != addr_seen[addr_seen.size()-1]) addr_seen.push_back(int'(addr));
    end
    ena   = 1'b1;
    start = 1'b0;

    got_e = sb.pop_front();
    check({name, "_done_edge"},  32'(ecnt),       32'(got_e.done_edge));
    check({name, "_busy_done"},  32'(busy),       32'd0);
    check({name, "_result"},     32'(results),    32'(got_e.res));
    check({name, "_result_nr"},  32'(results_nr), 32'(got_e.res_nr));
    check({name, "_done_nr"},    32'(done_nr),    32'd1);
    check({name, "_addr_count"}, 32'(addr_seen.size()), 32'(N_OUT*CHUNKS));
    for (int i = 0; i < addr_seen.size() && i < N_OUT*CHUNKS; i++) begin
      check({name, "_addr_seq"}, 32'(addr_seen[i]), 32'(BASE_ADDR + i));
    end
  endtask

  initial begin
    int ecnt;
    for (int i = 0; i < (1<<ADDR_W); i++) rom_mem[i] = '0;
    iRst          = 1'b1;
    ena           = 1'b1;
    start         = 1'b0;
    data_from_ram = '0;
    tick();
    tick();
    check("rst_done",    32'(done),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_addr",    32'(addr),    32'd0);
    check("rst_results", 32'(results), 32'd0);
    check("rst_opr1",    32'(opr1),    32'd0);
    iRst = 1'b0;
    tick();

    run_pass("ones",    1,   1,   1,   0, 0, 11);
    run_pass("sat_pos", 127, 127, 127, 0, 0, 11);
    run_pass("neg",     -1,  -1,  5,   0, 0, 11);
    run_pass("slots",   1,   2,   3,   0, 0, 11);
    run_pass("ena_gap", 1,   1,   1,   5, 0, 14);

    // Reset in the middle of a pass, at edge 5 counted from the accept edge.
    load(1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    ecnt  = 1;
    while (ecnt < 4) begin
      tick();
      ecnt++;
    end
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check("midrst_done",    32'(done),    32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_addr",    32'(addr),    32'd0);
    check("midrst_results", 32'(results), 32'd0);
    tick();
    run_pass("after_rst", 1, 1, 1, 0, 0, 11);

    // A start while busy is ignored. A start in DONE begins a fresh pass.
    run_pass("repulse",   1, 1, 1, 0, 4, 11);
    run_pass("from_done", 1, 1, 2, 0, 0, 11);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
